// File: rtl/shift_reg_pkg.sv
// Shared types and helpers for the universal shift register.
// Optional feature macro: USR_ARITH_SHIFT_EN (mode 110 becomes arithmetic shift right).
package shift_reg_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SHL  = 3'b001,
    MODE_SHR  = 3'b010,
    MODE_LOAD = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_ASR  = 3'b110,
    MODE_CLR  = 3'b111
  } shift_mode_e;

  // True for every mode that advances the bit counter.
  function automatic logic is_shift(input shift_mode_e mode);
    logic res;
    case (mode)
      MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR: res = 1'b1;
`ifdef USR_ARITH_SHIFT_EN
      MODE_ASR: res = 1'b1;
`else
      MODE_ASR: res = 1'b0;
`endif
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/shift_bit_counter.sv
// Modulo-WIDTH shift counter with a registered one-cycle wrap pulse.
// Wraps explicitly at WIDTH-1 so non-power-of-two widths work.
module shift_bit_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_r;
  logic             wrap_r;

  // Count shifts; clear wins over increment, wrap pulses only on the wrapping shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r  <= {CNT_W{1'b0}};
      wrap_r <= 1'b0;
    end else if (clr) begin
      cnt_r  <= {CNT_W{1'b0}};
      wrap_r <= 1'b0;
    end else if (inc) begin
      if (cnt_r == LAST_CNT) begin
        cnt_r  <= {CNT_W{1'b0}};
        wrap_r <= 1'b1;
      end else begin
        cnt_r  <= cnt_r + CNT_W'(1);
        wrap_r <= 1'b0;
      end
    end else begin
      cnt_r  <= cnt_r;
      wrap_r <= 1'b0;
    end
  end

  assign count = cnt_r;
  assign wrap  = wrap_r;

endmodule

// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register: hold/shift/rotate/load/clear with word counter.
// Optional feature macro: USR_ARITH_SHIFT_EN enables mode 110 as arithmetic shift right.
module universal_shift_register
  import shift_reg_pkg::*;
#(
  parameter  int               WIDTH     = 8,
  parameter  logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  localparam int               CNT_W     = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin_lsb,
  input  logic             sin_msb,
  input  logic [WIDTH-1:0] parallel_in,
  output logic [WIDTH-1:0] parallel_out,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             word_done
);

  shift_mode_e      mode_s;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] next_q_s;
  logic             clr_s;
  logic             inc_s;

  assign mode_s = shift_mode_e'(mode);

  // Datapath mux selecting the next register contents.
  always_comb begin
    next_q_s = q_r;
    if (en) begin
      case (mode_s)
        MODE_HOLD: next_q_s = q_r;
        MODE_SHL:  next_q_s = {q_r[WIDTH-2:0], sin_lsb};
        MODE_SHR:  next_q_s = {sin_msb, q_r[WIDTH-1:1]};
        MODE_LOAD: next_q_s = parallel_in;
        MODE_ROL:  next_q_s = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
        MODE_ROR:  next_q_s = {q_r[0], q_r[WIDTH-1:1]};
`ifdef USR_ARITH_SHIFT_EN
        MODE_ASR:  next_q_s = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
`else
        MODE_ASR:  next_q_s = q_r;
`endif
        MODE_CLR:  next_q_s = {WIDTH{1'b0}};
        default:   next_q_s = q_r;
      endcase
    end else begin
      next_q_s = q_r;
    end
  end

  // Register; CLR deliberately goes to zero, only reset restores RESET_VAL.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r <= RESET_VAL;
    end else begin
      q_r <= next_q_s;
    end
  end

  assign clr_s = en & ((mode_s == MODE_LOAD) | (mode_s == MODE_CLR));
  assign inc_s = en & is_shift(mode_s);

  shift_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_s),
    .inc   (inc_s),
    .count (shift_cnt),
    .wrap  (word_done)
  );

  assign parallel_out = q_r;
  assign sout_msb     = q_r[WIDTH-1];
  assign sout_lsb     = q_r[0];

endmodule

// File: tb/tb_universal_shift_register.sv
// Randomised and directed bench for universal_shift_register (WIDTH=8 and WIDTH=5)
// against an integer-arithmetic reference model.
module tb_universal_shift_register;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance signals
  logic       reset8, en8, sl8, sm8;
  logic [2:0] mode8;
  logic [7:0] pin8, po8;
  logic       so_msb8, so_lsb8, wd8;
  logic [2:0] cnt8;

  // WIDTH=5 instance signals
  logic       reset5, en5, sl5, sm5;
  logic [2:0] mode5;
  logic [4:0] pin5, po5;
  logic       so_msb5, so_lsb5, wd5;
  logic [2:0] cnt5;

  universal_shift_register #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset8), .en(en8), .mode(mode8), .sin_lsb(sl8), .sin_msb(sm8),
    .parallel_in(pin8), .parallel_out(po8), .sout_msb(so_msb8), .sout_lsb(so_lsb8),
    .shift_cnt(cnt8), .word_done(wd8)
  );

  universal_shift_register #(.WIDTH(5)) dut5 (
    .clk(clk), .reset(reset5), .en(en5), .mode(mode5), .sin_lsb(sl5), .sin_msb(sm5),
    .parallel_in(pin5), .parallel_out(po5), .sout_msb(so_msb5), .sout_lsb(so_lsb5),
    .shift_cnt(cnt5), .word_done(wd5)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // model state per instance: register value, count, word_done
  int mq8, mc8, md8;
  int mq5, mc5, md5;
  int wd_pulses;

`ifdef USR_ARITH_SHIFT_EN
  localparam bit ASR_ON = 1'b1;
`else
  localparam bit ASR_ON = 1'b0;
`endif

  task automatic check(input string tag, input int observed, input int expected);
    n_checks++;
    if (observed == expected) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  tag, observed, observed, expected, expected, $time);
  endtask

  function automatic int model_next_q(int w, int q, bit e, int m, bit sl, bit sm, int pin);
    int full = 1 << w;
    int top  = full / 2;
    if (!e) return q;
    case (m)
      1: return (q * 2 + int'(sl)) % full;
      2: return q / 2 + (sm ? top : 0);
      3: return pin % full;
      4: return (q * 2) % full + q / top;
      5: return q / 2 + (q % 2) * top;
      6: return ASR_ON ? (q / 2 + (q >= top ? top : 0)) : q;
      7: return 0;
      default: return q;
    endcase
  endfunction

  function automatic bit model_counts(bit e, int m);
    return e && (m == 1 || m == 2 || m == 4 || m == 5 || (m == 6 && ASR_ON));
  endfunction

  task automatic model_step(input int w, input bit r, input bit e, input int m,
                            input bit sl, input bit sm, input int pin,
                            inout int q, inout int c, inout int d);
    if (r) begin
      q = 0; c = 0; d = 0;
    end else begin
      q = model_next_q(w, q, e, m, sl, sm, pin);
      if (e && (m == 3 || m == 7)) begin
        c = 0; d = 0;
      end else if (model_counts(e, m)) begin
        c = (c + 1) % w;
        d = (c == 0) ? 1 : 0;
      end else begin
        d = 0;
      end
    end
  endtask

  task automatic cyc8(input bit r, input bit e, input int m, input bit sl, input bit sm, input int pin);
    reset8 = r; en8 = e; mode8 = 3'(m); sl8 = sl; sm8 = sm; pin8 = 8'(pin);
    model_step(8, r, e, m, sl, sm, pin, mq8, mc8, md8);
    @(posedge clk); #1;
    check("po8", int'(po8), mq8);
    check("sout_msb8", int'(so_msb8), mq8 / 128);
    check("sout_lsb8", int'(so_lsb8), mq8 % 2);
    check("cnt8", int'(cnt8), mc8);
    check("wd8", int'(wd8), md8);
  endtask

  task automatic cyc5(input bit r, input bit e, input int m, input bit sl, input bit sm, input int pin);
    reset5 = r; en5 = e; mode5 = 3'(m); sl5 = sl; sm5 = sm; pin5 = 5'(pin);
    model_step(5, r, e, m, sl, sm, pin, mq5, mc5, md5);
    @(posedge clk); #1;
    check("po5", int'(po5), mq5);
    check("sout_msb5", int'(so_msb5), mq5 / 16);
    check("sout_lsb5", int'(so_lsb5), mq5 % 2);
    check("cnt5", int'(cnt5), mc5);
    check("wd5", int'(wd5), md5);
  endtask

  initial begin
    bit seq [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    reset8 = 1'b1; en8 = 1'b0; mode8 = 3'd0; sl8 = 1'b0; sm8 = 1'b0; pin8 = 8'h00;
    reset5 = 1'b1; en5 = 1'b0; mode5 = 3'd0; sl5 = 1'b0; sm5 = 1'b0; pin5 = 5'h00;
    mq8 = 0; mc8 = 0; md8 = 0; mq5 = 0; mc5 = 0; md5 = 0;

    // 1. reset has priority over a load
    cyc8(1, 1, 3, 0, 0, 8'hFF);
    check("t1_po", int'(po8), 0);
    check("t1_cnt", int'(cnt8), 0);

    // 2. load A5 then shift out MSB first
    cyc8(0, 1, 3, 0, 0, 8'hA5);
    check("t2_msb0", int'(so_msb8), int'(seq[0]));
    for (int i = 1; i <= 8; i++) begin
      cyc8(0, 1, 1, 0, 0, 0);
      if (i < 8) check("t2_msb", int'(so_msb8), int'(seq[i]));
    end
    check("t2_po_end", int'(po8), 0);
    check("t2_wd_end", int'(wd8), 1);
    check("t2_cnt_end", int'(cnt8), 0);
    cyc8(0, 1, 0, 0, 0, 0);
    check("t2_wd_drop", int'(wd8), 0);

    // 3. rotate right a full word
    cyc8(0, 1, 3, 0, 0, 8'h81);
    cyc8(0, 1, 5, 0, 0, 0);
    check("t3_ror1", int'(po8), 8'hC0);
    check("t3_cnt1", int'(cnt8), 1);
    for (int i = 0; i < 7; i++) cyc8(0, 1, 5, 0, 0, 0);
    check("t3_po", int'(po8), 8'h81);
    check("t3_wd", int'(wd8), 1);

    // 4. enable gating, partial word, load/clear discard the count
    for (int i = 0; i < 3; i++) cyc8(0, 0, 1, 1, 1, 0);
    check("t4_gated", int'(po8), 8'h81);
    cyc8(0, 1, 7, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc8(0, 1, 2, 0, 1, 0);
    check("t4_shr", int'(po8), 8'hE0);
    check("t4_cnt", int'(cnt8), 3);
    cyc8(0, 1, 3, 0, 0, 8'h3C);
    check("t4_ld_cnt", int'(cnt8), 0);
    check("t4_ld_wd", int'(wd8), 0);
    cyc8(0, 1, 7, 0, 0, 0);
    check("t4_clr", int'(po8), 0);

    // load/clear at count WIDTH-1 must not raise word_done
    cyc8(0, 1, 3, 0, 0, 8'h11);
    for (int i = 0; i < 7; i++) cyc8(0, 1, 4, 0, 0, 0);
    cyc8(0, 1, 7, 0, 0, 0);
    check("t4_clr_at_last", int'(wd8), 0);

    // 5. mode 110
    cyc8(0, 1, 3, 0, 0, 8'h90);
    cyc8(0, 1, 6, 0, 0, 0);
    check("t5_po", int'(po8), ASR_ON ? 8'hC8 : 8'h90);
    check("t5_cnt", int'(cnt8), ASR_ON ? 1 : 0);

    // reset mid-word discards the count
    cyc8(0, 1, 1, 1, 0, 0);
    cyc8(1, 1, 1, 1, 0, 0);
    check("t5_rst_cnt", int'(cnt8), 0);

    // randomised WIDTH=8 traffic
    for (int i = 0; i < 400; i++)
      cyc8(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) != 0), int'($urandom_range(0, 7)),
           1'($urandom), 1'($urandom), int'($urandom_range(0, 255)));

    // 6. WIDTH=5 wraps at 4, not at 7
    cyc5(1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      cyc5(0, 1, 1, 1, 0, 0);
      check("t6_wd5", int'(wd5), (i == 5) ? 1 : 0);
    end
    check("t6_cnt5", int'(cnt5), 0);
    wd_pulses = 0;
    for (int i = 0; i < 10; i++) begin
      cyc5(0, 1, 1, 0, 0, 0);
      wd_pulses += int'(wd5);
    end
    check("t6_pulses", wd_pulses, 2);

    for (int i = 0; i < 300; i++)
      cyc5(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) != 0), int'($urandom_range(0, 7)),
           1'($urandom), 1'($urandom), int'($urandom_range(0, 31)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
- Parametrised successor to the team's fixed 4-bit serial-in serial-out shift register.
- WIDTH-bit universal shift register with these operations: hold, shift left, shift right, rotate left, rotate right, parallel load and clear.
- Serial in and serial out are available at both ends.
- A built-in bit counter flags each completed word of WIDTH shifts.
- Used as the common building block for serialisers and deserialisers in the SEQUENTIAL library.

Parameters:
- WIDTH, 8, register width in bits. Must be at least 2.
- RESET_VAL, {WIDTH{1'b0}}, register contents after reset.
- CNT_W (localparam), max(1,$clog2(WIDTH)), width of the bit counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  operation enable. When 0, all state holds.
- mode  input  3  operation select (see Behaviour).
- sin_lsb  input  1  serial input that enters bit 0 on shift left.
- sin_msb  input  1  serial input that enters bit WIDTH-1 on shift right.
- parallel_in  input  WIDTH  load data.
- parallel_out  output  WIDTH  register contents.
- sout_msb  output  1  equals parallel_out[WIDTH-1].
- sout_lsb  output  1  equals parallel_out[0].
- shift_cnt  output  CNT_W  number of shifts/rotates since the last load/clear, modulo WIDTH.
- word_done  output  1  one-cycle pulse when a word completes.

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - reset is synchronous and active-high, sampled at the rising edge of clk.
  - reset has priority over en and mode.
- Reset values:
  - parallel_out = RESET_VAL.
  - shift_cnt = 0.
  - word_done = 0.
  - sout_msb and sout_lsb follow the register contents.
- Output timing:
  - All state is registered.
  - sout_msb and sout_lsb are combinational taps of the register, so there is no added latency: they reflect the new contents in the cycle after the edge.
- mode encoding, effective only when en=1:
  - 000 HOLD: q unchanged.
  - 001 SHL: q <= {q[WIDTH-2:0], sin_lsb}.
  - 010 SHR: q <= {sin_msb, q[WIDTH-1:1]}.
  - 011 LOAD: q <= parallel_in.
  - 100 ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - 101 ROR: q <= {q[0], q[WIDTH-1:1]}.
  - 110 ASR: optional feature. Without the macro it behaves as HOLD.
  - 111 CLR: q <= 0. Note this is 0, not RESET_VAL.
- Counter:
  - SHL, SHR, ROL, ROR and ASR (when enabled) each increment shift_cnt.
  - When shift_cnt is at WIDTH-1, the next shift wraps it to 0 and sets word_done=1 for exactly one cycle.
  - LOAD and CLR force shift_cnt to 0 and word_done to 0, even if the count was at WIDTH-1.
  - HOLD, or en=0, keeps shift_cnt unchanged and drives word_done=0.
  - word_done is registered and asserts in the same cycle the wrapped count becomes visible.
- Boundary conditions:
  - For non-power-of-two WIDTH, the counter must wrap explicitly at WIDTH-1, not at 2^CNT_W.
  - Reset mid-word discards the partial count.

Optional Feature:
- Macro: USR_ARITH_SHIFT_EN.
- Defined: mode 110 performs an arithmetic shift right, q <= {q[WIDTH-1], q[WIDTH-1:1]}. It counts as a shift for shift_cnt and word_done.
- Undefined: mode 110 is treated as HOLD. No count change, word_done=0.

Decomposition:
- Package shift_reg_pkg:
  - typedef enum logic [2:0] shift_mode_e: MODE_HOLD, MODE_SHL, MODE_SHR, MODE_LOAD, MODE_ROL, MODE_ROR, MODE_ASR, MODE_CLR.
  - Function is_shift(mode): returns 1 for the counting modes.
- Sub-module shift_bit_counter: parametrised modulo-WIDTH counter with clear and increment inputs, producing count and a wrap pulse.
- The datapath mux stays in the top module.

Test Plan (WIDTH=8, RESET_VAL=0):
1. Reset and priority: reset=1 together with en=1, mode=LOAD, parallel_in=8'hFF -> parallel_out=8'h00, shift_cnt=0, word_done=0.
2. Load then shift out:
   - LOAD 8'hA5, then 8×SHL with sin_lsb=0.
   - sout_msb after the load and after each of shifts 1–7 reads 1,0,1,0,0,1,0,1.
   - After the 8th shift: parallel_out=8'h00, word_done=1 for that cycle only, shift_cnt=0.
3. Rotate:
   - LOAD 8'h81, ROR once -> 8'hC0, shift_cnt=1.
   - 7 more ROR -> 8'h81, word_done pulse.
4. Enable gating and partial word:
   - en=0 with mode=SHL for 3 cycles -> no change.
   - 3×SHR with sin_msb=1 from 8'h00 -> 8'hE0, shift_cnt=3.
   - Then LOAD 8'h3C -> shift_cnt=0, no word_done.
   - Then CLR -> 8'h00.
5. Optional feature: LOAD 8'h90, mode=110.
   - With USR_ARITH_SHIFT_EN: 8'hC8, shift_cnt=1.
   - Without it: 8'h90, shift_cnt=0.
6. Non-power-of-two width: WIDTH=5.
   - 5×SHL -> word_done on the 5th shift, shift_cnt back to 0.
   - 10×SHL -> exactly two word_done pulses.
